// File: rtl/sdram_txn_scoreboard.sv
// sdram_txn_scoreboard
//   Passive transaction-level scoreboard for the SDRAM AHB-slave environment.
//   Accepted writes are stored in a tagged shadow memory; each accepted read
//   pushes {known, expected data} into an outstanding-read FIFO. When the DUV
//   strobes read data, the FIFO head is popped and compared. Counters, sticky
//   FIFO flags and per-bank coverage bins are kept alongside.
//
//   Optional build macro: SCB_STOP_ON_ERROR_EN. When defined, the first
//   mismatch freezes the scoreboard (halted) until reset. When undefined,
//   halted is always 0.
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   mon_hsel/hwrite/haddr/hwdata/hready   monitored AHB signals
//   duv_rvalid, duv_rdata                 DUV read-data strobe and data
//   error_detected     one-cycle pulse per mismatch
//   error_count        mismatches (saturating)
//   compare_count      completed comparisons of known data (saturating)
//   unknown_count      reads of unwritten/aliased addresses (saturating)
//   pend_level         outstanding-read FIFO occupancy
//   overflow/underflow sticky FIFO boundary flags
//   cov_bins           bit 2b: bank b written, bit 2b+1: bank b read
//   cov_count          number of set cov_bins bits
//   halted             stop-on-error state
module sdram_txn_scoreboard #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BANK_LSB  = 14,
  parameter int BANK_W    = 2,
  parameter int SHADOW_AW = 6,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mon_hsel,
  input  logic                           mon_hwrite,
  input  logic [ADDR_W-1:0]              mon_haddr,
  input  logic [DATA_W-1:0]              mon_hwdata,
  input  logic                           mon_hready,
  input  logic                           duv_rvalid,
  input  logic [DATA_W-1:0]              duv_rdata,
  output logic                           error_detected,
  output logic [CNT_W-1:0]               error_count,
  output logic [CNT_W-1:0]               compare_count,
  output logic [CNT_W-1:0]               unknown_count,
  output logic [$clog2(DEPTH):0]         pend_level,
  output logic                           overflow,
  output logic                           underflow,
  output logic [2*(2**BANK_W)-1:0]       cov_bins,
  output logic [$clog2(2*(2**BANK_W)):0] cov_count,
  output logic                           halted
);

  localparam int BANKS  = 2**BANK_W;
  localparam int PW     = $clog2(DEPTH);
  localparam int COV_N  = 2*BANKS;
  localparam int COVC_W = $clog2(COV_N) + 1;
  localparam int SH_N   = 2**SHADOW_AW;
  localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic                 stop_now;
  logic                 wr_acc, rd_acc, rv;
  logic [BANK_W-1:0]    bank;
  logic [SHADOW_AW-1:0] idx;
  logic                 lookup_known;
  logic                 push, pop, mismatch;
  logic                 head_known;
  logic [DATA_W-1:0]    head_data;

  logic [SH_N-1:0]      sh_valid_q, sh_valid_d;
  logic [ADDR_W-1:0]    sh_tag_mem  [SH_N];
  logic [DATA_W-1:0]    sh_data_mem [SH_N];

  logic                 fifo_known_mem [DEPTH];
  logic [DATA_W-1:0]    fifo_data_mem  [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]          level_q, level_d;

  logic                 err_det_q, err_det_d;
  logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]     cmp_cnt_q, cmp_cnt_d;
  logic [CNT_W-1:0]     unk_cnt_q, unk_cnt_d;
  logic                 over_q, over_d, under_q, under_d;
  logic [COV_N-1:0]     cov_bins_q, cov_bins_d;
  logic [COVC_W-1:0]    cov_cnt_q, cov_cnt_d;
  logic                 halted_q, halted_d;

  always_comb begin
`ifdef SCB_STOP_ON_ERROR_EN
    stop_now = halted_q;
`else
    stop_now = 1'b0;
`endif
    wr_acc = !stop_now && mon_hsel && mon_hwrite && mon_hready;
    rd_acc = !stop_now && mon_hsel && !mon_hwrite && mon_hready;
    rv     = !stop_now && duv_rvalid;
    bank   = mon_haddr[BANK_LSB +: BANK_W];
    idx    = mon_haddr[SHADOW_AW-1:0];
    // Full-address tag match rejects aliases that share the shadow index.
    lookup_known = sh_valid_q[idx] && (sh_tag_mem[idx] == mon_haddr);
    head_known   = fifo_known_mem[rd_ptr_q];
    head_data    = fifo_data_mem[rd_ptr_q];
    // An rvalid against an empty FIFO never pops, even if a push lands now.
    pop      = rv && (level_q != '0);
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    push     = rd_acc && ((level_q != FULL_LVL) || pop);
    mismatch = pop && head_known && (head_data != duv_rdata);

    sh_valid_d = sh_valid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_det_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    cmp_cnt_d  = cmp_cnt_q;
    unk_cnt_d  = unk_cnt_q;
    over_d     = over_q;
    under_d    = under_q;
    cov_bins_d = cov_bins_q;

    if (wr_acc) begin
      sh_valid_d[idx]              = 1'b1;
      cov_bins_d[{bank, 1'b0}]     = 1'b1;
    end
    if (rd_acc) begin
      cov_bins_d[{bank, 1'b1}]     = 1'b1;
      if (!push) over_d = 1'b1;
    end
    if (rv && (level_q == '0)) under_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      if (head_known) begin
        cmp_cnt_d = sat_inc(cmp_cnt_q);
        if (mismatch) begin
          err_cnt_d = sat_inc(err_cnt_q);
          err_det_d = 1'b1;
        end
      end else begin
        unk_cnt_d = sat_inc(unk_cnt_q);
      end
    end
    level_d = level_q + (PW+1)'(push) - (PW+1)'(pop);

`ifdef SCB_STOP_ON_ERROR_EN
    halted_d = halted_q || mismatch;
`else
    halted_d = 1'b0;
`endif

    // Tracks cov_bins with a one-cycle lag.
    cov_cnt_d = '0;
    for (int i = 0; i < COV_N; i++) cov_cnt_d = cov_cnt_d + COVC_W'(cov_bins_q[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_valid_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      err_det_q  <= 1'b0;
      err_cnt_q  <= '0;
      cmp_cnt_q  <= '0;
      unk_cnt_q  <= '0;
      over_q     <= 1'b0;
      under_q    <= 1'b0;
      cov_bins_q <= '0;
      cov_cnt_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      sh_valid_q <= sh_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      err_det_q  <= err_det_d;
      err_cnt_q  <= err_cnt_d;
      cmp_cnt_q  <= cmp_cnt_d;
      unk_cnt_q  <= unk_cnt_d;
      over_q     <= over_d;
      under_q    <= under_d;
      cov_bins_q <= cov_bins_d;
      cov_cnt_q  <= cov_cnt_d;
      halted_q   <= halted_d;
    end
  end

  // Storage arrays need no reset: validity lives in sh_valid_q and the FIFO pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      sh_tag_mem[idx]  <= mon_haddr;
      sh_data_mem[idx] <= mon_hwdata;
    end
    if (push) begin
      fifo_known_mem[wr_ptr_q] <= lookup_known;
      fifo_data_mem[wr_ptr_q]  <= sh_data_mem[idx];
    end
  end

  assign error_detected = err_det_q;
  assign error_count    = err_cnt_q;
  assign compare_count  = cmp_cnt_q;
  assign unknown_count  = unk_cnt_q;
  assign pend_level     = level_q;
  assign overflow       = over_q;
  assign underflow      = under_q;
  assign cov_bins       = cov_bins_q;
  assign cov_count      = cov_cnt_q;
  assign halted         = halted_q;

endmodule

// File: tb/tb_sdram_txn_scoreboard.sv
module tb_sdram_txn_scoreboard;
  localparam int DEPTH = 4;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mon_hsel = 1'b0, mon_hwrite = 1'b0, mon_hready = 1'b0;
  logic [31:0] mon_haddr = '0, mon_hwdata = '0;
  logic        duv_rvalid = 1'b0;
  logic [31:0] duv_rdata = '0;
  logic        error_detected, overflow, underflow, halted;
  logic [15:0] error_count, compare_count, unknown_count;
  logic [2:0]  pend_level;
  logic [7:0]  cov_bins;
  logic [3:0]  cov_count;

  always #5 clk = ~clk;

  sdram_txn_scoreboard dut (
    .clk(clk), .reset(reset),
    .mon_hsel(mon_hsel), .mon_hwrite(mon_hwrite), .mon_haddr(mon_haddr),
    .mon_hwdata(mon_hwdata), .mon_hready(mon_hready),
    .duv_rvalid(duv_rvalid), .duv_rdata(duv_rdata),
    .error_detected(error_detected), .error_count(error_count),
    .compare_count(compare_count), .unknown_count(unknown_count),
    .pend_level(pend_level), .overflow(overflow), .underflow(underflow),
    .cov_bins(cov_bins), .cov_count(cov_count), .halted(halted)
  );

  int checks = 0, passes = 0, fails = 0;

  // Reference model: shadow as associative arrays keyed by index, FIFO as a queue.
  typedef struct { bit known; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] sh_tag [int];
  logic [31:0] sh_data[int];
  bit          m_err_det, m_over, m_under, m_halted;
  int          m_err, m_cmp, m_unk, m_covcnt;
  logic [7:0]  m_cov;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit hsel, input bit hwrite, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hready, input bit rvalid,
                       input logic [31:0] rdata);
    int idx, bank;
    ent_t e;
    if (rst) begin
      mq.delete(); sh_tag.delete(); sh_data.delete();
      m_err_det = 0; m_over = 0; m_under = 0; m_halted = 0;
      m_err = 0; m_cmp = 0; m_unk = 0; m_covcnt = 0; m_cov = '0;
      return;
    end
    m_covcnt  = $countones(m_cov);
    m_err_det = 0;
    if (m_halted) return;
    idx  = int'(addr & 32'h3F);
    bank = int'((addr >> 14) & 32'h3);
    if (rvalid) begin
      if (mq.size() == 0) m_under = 1;
      else begin
        e = mq.pop_front();
        if (!e.known) m_unk = sat(m_unk);
        else begin
          m_cmp = sat(m_cmp);
          if (e.data !== rdata) begin
            m_err = sat(m_err);
            m_err_det = 1;
`ifdef SCB_STOP_ON_ERROR_EN
            m_halted = 1;
`endif
          end
        end
      end
    end
    if (hsel && hready && hwrite) begin
      sh_tag[idx] = addr; sh_data[idx] = wdata;
      m_cov[2*bank] = 1'b1;
    end
    if (hsel && hready && !hwrite) begin
      e.known = sh_tag.exists(idx) && (sh_tag[idx] == addr);
      e.data  = sh_data.exists(idx) ? sh_data[idx] : 32'h0;
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_over = 1;
      m_cov[2*bank+1] = 1'b1;
    end
  endtask

  task automatic step(input bit rst, input bit hsel, input bit hwrite, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hready, input bit rvalid,
                      input logic [31:0] rdata);
    reset = rst; mon_hsel = hsel; mon_hwrite = hwrite; mon_haddr = addr;
    mon_hwdata = wdata; mon_hready = hready; duv_rvalid = rvalid; duv_rdata = rdata;
    model(rst, hsel, hwrite, addr, wdata, hready, rvalid, rdata);
    @(posedge clk); #1;
    chk("error_detected", 64'(error_detected), 64'(m_err_det));
    chk("error_count",    64'(error_count),    64'(m_err));
    chk("compare_count",  64'(compare_count),  64'(m_cmp));
    chk("unknown_count",  64'(unknown_count),  64'(m_unk));
    chk("pend_level",     64'(pend_level),     64'(mq.size()));
    chk("overflow",       64'(overflow),       64'(m_over));
    chk("underflow",      64'(underflow),      64'(m_under));
    chk("cov_bins",       64'(cov_bins),       64'(m_cov));
    chk("cov_count",      64'(cov_count),      64'(m_covcnt));
    chk("halted",         64'(halted),         64'(m_halted));
  endtask

  task automatic rst_cyc();                         step(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic idle();                            step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(0, 1, 1, a, d, 1, 0, 0); endtask
  task automatic rd(input logic [31:0] a);          step(0, 1, 0, a, 0, 1, 0, 0); endtask
  task automatic rv(input logic [31:0] d);          step(0, 0, 0, 0, 0, 0, 1, d); endtask

  initial begin
    // Reset state
    rst_cyc();
    chk("rst_err_cnt", 64'(error_count), 64'd0);
    chk("rst_cov_bins", 64'(cov_bins), 64'd0);

    // Matching write/read
    wr(32'h8000_0000, 32'h4985_6712);
    rd(32'h8000_0000);
    rv(32'h4985_6712);
    chk("tp1_compare_count", 64'(compare_count), 64'd1);
    chk("tp1_error_count",   64'(error_count),   64'd0);
    chk("tp1_cov_bins",      64'(cov_bins),      64'h3);

    // Mismatch
    rst_cyc();
    wr(32'h8000_0000, 32'h4985_6712);
    rd(32'h8000_0000);
    rv(32'h4985_6713);
    chk("tp2_error_detected", 64'(error_detected), 64'd1);
    chk("tp2_error_count",    64'(error_count),    64'd1);
    idle();
    chk("tp2_pulse_end", 64'(error_detected), 64'd0);
    wr(32'h8000_0000, 32'h5);
    rd(32'h8000_0000);
    rv(32'h5);
`ifdef SCB_STOP_ON_ERROR_EN
    chk("tp2_halted",       64'(halted),        64'd1);
    chk("tp2_frozen_cmp",   64'(compare_count), 64'd1);
    chk("tp2_frozen_err",   64'(error_count),   64'd1);
    chk("tp2_frozen_level", 64'(pend_level),    64'd0);
`else
    chk("tp2_halted",       64'(halted),        64'd0);
    chk("tp2_cmp_cont",     64'(compare_count), 64'd2);
`endif

    // Read of an unwritten address
    rst_cyc();
    rd(32'h8000_4000);
    rv(32'h0);
    chk("tp3_unknown", 64'(unknown_count), 64'd1);
    chk("tp3_compare", 64'(compare_count), 64'd0);
    chk("tp3_cov_bins", 64'(cov_bins), 64'h8);

    // Alias: same index, different tag
    rst_cyc();
    wr(32'h8000_0001, 32'h1234);
    rd(32'h8000_0041);
    rv(32'h1234);
    chk("tp4_unknown", 64'(unknown_count), 64'd1);
    chk("tp4_error",   64'(error_count),   64'd0);

    // FIFO overflow then drain and underflow
    rst_cyc();
    for (int i = 0; i < 5; i++) rd(32'h8000_0000 + 32'(i*4));
    chk("tp5_level_full", 64'(pend_level), 64'd4);
    chk("tp5_overflow",   64'(overflow),   64'd1);
    for (int i = 0; i < 4; i++) rv(32'h0);
    chk("tp5_level_empty", 64'(pend_level), 64'd0);
    chk("tp5_no_underflow", 64'(underflow), 64'd0);
    rv(32'h0);
    chk("tp5_underflow", 64'(underflow), 64'd1);

    // Simultaneous push and pop, then mid-sequence reset
    rst_cyc();
    wr(32'h8000_0010, 32'hA5);
    rd(32'h8000_0010);
    chk("tp6_level1", 64'(pend_level), 64'd1);
    step(0, 1, 0, 32'h8000_0010, 0, 1, 1, 32'hA5);
    chk("tp6_cmp",       64'(compare_count), 64'd1);
    chk("tp6_level_hold", 64'(pend_level),   64'd1);
    rst_cyc();
    chk("tp6_rst_level", 64'(pend_level), 64'd0);
    chk("tp6_rst_cmp",   64'(compare_count), 64'd0);
    chk("tp6_rst_cov",   64'(cov_bins), 64'd0);
    rd(32'h8000_0010);
    rv(32'hA5);
    chk("tp6_unknown_after_rst", 64'(unknown_count), 64'd1);
    chk("tp6_cmp_after_rst",     64'(compare_count), 64'd0);

    // Randomized traffic against the model
    rst_cyc();
    for (int n = 0; n < 400; n++) begin
      bit          r, hs, hw, hr, v;
      logic [31:0] a, d, rdat;
      r  = ($urandom_range(0, 63) == 0);
      hs = ($urandom_range(0, 9) < 8);
      hw = 1'($urandom_range(0, 1));
      hr = ($urandom_range(0, 4) != 0);
      a  = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 14)
                         | (32'($urandom_range(0, 1)) << 6) | 32'($urandom_range(0, 3));
      d  = $urandom;
      v  = ($urandom_range(0, 9) < 4);
      rdat = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].data : $urandom;
      step(r, hs, hw, a, d, hr, v, rdat);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sdram_txn_scoreboard.md
Name: sdram_txn_scoreboard

Overview:
- Parametrised, transaction-level scoreboard for the SDRAM AHB-slave verification environment.
- Passively monitors the bus: tracks write data in a tagged shadow memory and queues the expected data for each read request in an outstanding-read FIFO.
- Compares each expected value against the DUV read data when the DUV strobes it.
- Keeps error, compare and unknown counters, sticky overflow/underflow flags, and per-bank read/write coverage bins.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 32, bus address width.
- BANK_LSB, 14, LSB of the bank field in the address.
- BANK_W, 2, bank field width; BANKS = 2**BANK_W.
- SHADOW_AW, 6, shadow memory index width; 2**SHADOW_AW entries.
- DEPTH, 4, outstanding-read FIFO depth (power of two, ≥2).
- CNT_W, 16, counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mon_hsel  in  1  monitored HSEL.
- mon_hwrite  in  1  monitored HWRITE.
- mon_haddr  in  ADDR_W  monitored HADDR.
- mon_hwdata  in  DATA_W  monitored HWDATA, valid in the same cycle as the address.
- mon_hready  in  1  monitored HREADY.
- duv_rvalid  in  1  DUV read-data strobe.
- duv_rdata  in  DATA_W  DUV HRDATA.
- error_detected  out  1  one-cycle pulse per mismatch.
- error_count  out  CNT_W  mismatches.
- compare_count  out  CNT_W  completed comparisons.
- unknown_count  out  CNT_W  reads of unwritten or aliased addresses.
- pend_level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky flag.
- underflow  out  1  sticky flag.
- cov_bins  out  2*BANKS  bit 2b = bank b written; bit 2b+1 = bank b read.
- cov_count  out  $clog2(2*BANKS)+1  number of set cov_bins.
- halted  out  1  stop-on-error state.

Behaviour:
- Reset: all outputs 0; all shadow valid bits cleared in the reset cycle; FIFO emptied. Reset asserted mid-operation discards pending reads and gives no compare.
- Accept conditions:
  - Write accepted in a cycle when mon_hsel & mon_hwrite & mon_hready.
  - Read accepted in a cycle when mon_hsel & !mon_hwrite & mon_hready.
- Bank and index: bank = mon_haddr[BANK_LSB+BANK_W-1:BANK_LSB]; idx = mon_haddr[SHADOW_AW-1:0].
- Shadow write: entry[idx] <= {valid=1, tag=mon_haddr, data=mon_hwdata}, visible from the next cycle. A later write to the same address overwrites it.
- Read lookup, done in the accept cycle:
  - known = valid & (tag == mon_haddr).
  - Push {known, data} into the FIFO.
  - An aliasing entry (valid but tag mismatch) gives known=0.
- FIFO boundaries:
  - Push while full with no pop: request dropped, overflow set.
  - Push while full with a pop in the same cycle: both proceed, level unchanged.
  - duv_rvalid while the FIFO is empty sets underflow and gives no compare, even if a push occurs in the same cycle.
- Compare, on duv_rvalid with the FIFO non-empty: pop the head, then one cycle later (registered):
  - known & (data != duv_rdata): error_detected=1, error_count+1, compare_count+1.
  - known & match: compare_count+1 only.
  - !known: unknown_count+1; error_count and compare_count unchanged.
- Counters saturate at all-ones.
- pend_level is updated the cycle after a push or pop.
- Coverage: cov_bins bits are set on accepted transactions (registered) and cleared only by reset. cov_count is the popcount of cov_bins, registered one cycle after cov_bins.
- A transaction with mon_hready=0 is ignored.

Optional Feature:
- Macro: SCB_STOP_ON_ERROR_EN.
- Defined:
  - The first mismatch sets halted (sticky until reset).
  - While halted: no shadow writes, FIFO pushes or pops, and no counter or coverage updates; all outputs hold their values.
  - error_detected pulses once only.
- Undefined: halted is tied 0 and checking continues indefinitely.

Test Plan:
- Write 0x49856712 @0x80000000, then read 0x80000000 with DUV returning 0x49856712 → compare_count=1, error_count=0, cov_bins=0b11.
- Same flow with DUV returning 0x49856713 → error_detected pulses one cycle after rvalid, error_count=1; with SCB_STOP_ON_ERROR_EN, halted=1 and a following write/read leaves all counters frozen.
- Read 0x80004000 before any write → unknown_count=1, compare_count=0, cov_bins bit 3 set.
- Write @0x80000001 then read 0x80000041 (same idx, tag differs) → unknown_count=1, no error.
- 5 back-to-back reads with no rvalid, DEPTH=4 → pend_level=4, overflow=1; then 4 rvalids → pend_level=0; a fifth rvalid → underflow=1.
- Read accepted and rvalid in the same cycle with pend_level=1 → head compared, pend_level stays 1; assert reset mid-sequence → all outputs 0 next cycle and the earlier write reads back as unknown.
